// File: rtl/dshot_pkg.sv
// Shared DShot definitions: value-range constants and the arming state encoding
// used by the decoder, the arming controller and telemetry.
package dshot_pkg;

  localparam logic [10:0] THROTTLE_MIN     = 11'd48;
  localparam logic [5:0]  CMD_BEACON_LO    = 6'd1;
  localparam logic [5:0]  CMD_BEACON_HI    = 6'd5;
  localparam logic [5:0]  CMD_DIR_1        = 6'd7;
  localparam logic [5:0]  CMD_DIR_2        = 6'd8;
  localparam logic [5:0]  CMD_DIR_NORMAL   = 6'd20;
  localparam logic [5:0]  CMD_DIR_REVERSED = 6'd21;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    FAILSAFE = 2'd2
  } dshot_state_e;

endpackage

// File: rtl/dshot_cmd_repeat.sv
// Repeat qualifier for DShot special commands: fires once, in the frame cycle,
// when the same command has been seen CMD_REPEAT times in a row.
module dshot_cmd_repeat #(
  parameter int CMD_REPEAT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       good_i,
  input  logic [5:0] value_i,
  input  logic       is_special_i,
  output logic       cmd_fire_o,
  output logic [5:0] cmd_code_o
);

  localparam int RW = $clog2(CMD_REPEAT + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(CMD_REPEAT);
  localparam logic [RW-1:0] REP_ONE = RW'(1);

  logic [5:0]    last_cmd_q, last_cmd_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    last_cmd_d = last_cmd_q;
    rep_cnt_d  = rep_cnt_q;
    cmd_fire_o = 1'b0;
    cmd_code_o = value_i;
    if (good_i) begin
      if (!is_special_i) begin
        rep_cnt_d = '0;
      end else if (value_i == last_cmd_q) begin
        // Saturated count means this command already fired; stay silent.
        if (rep_cnt_q != REP_MAX) begin
          rep_cnt_d  = rep_cnt_q + REP_ONE;
          cmd_fire_o = (rep_cnt_q == REP_MAX - REP_ONE);
        end
      end else begin
        last_cmd_d = value_i;
        rep_cnt_d  = REP_ONE;
        cmd_fire_o = (REP_MAX == REP_ONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_cmd_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      last_cmd_q <= last_cmd_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/dshot_arming_controller.sv
// Gatekeeper between the DShot frame decoder and the motor speed output:
// arming sequence, loss-of-signal failsafe, direction commands and beacons.
module dshot_arming_controller
  import dshot_pkg::*;
#(
  parameter int ARM_FRAMES     = 10,
  parameter int CMD_REPEAT     = 6,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_strobe,
  input  logic [10:0] frame_value,
  input  logic        frame_crc_ok,
  output logic [7:0]  speed_out,
  output logic        armed,
  output logic        failsafe,
  output logic        reversed,
  output logic        beep_strobe,
  output logic [2:0]  beep_tone
);

  localparam int ZW = $clog2(ARM_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ZW-1:0] ZERO_LAST = ZW'(ARM_FRAMES - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  dshot_state_e  state_q, state_d;
  logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    speed_q, speed_d;
  logic          reversed_q, reversed_d;
  logic          beep_q, beep_d;
  logic [2:0]    tone_q, tone_d;

  logic       good, is_zero, is_special, is_throttle, is_beacon, expire;
  logic       cmd_fire;
  logic [5:0] cmd_code;

  assign good        = frame_strobe & frame_crc_ok;
  assign is_zero     = (frame_value == '0);
  assign is_throttle = (frame_value >= THROTTLE_MIN);
  assign is_special  = !is_zero && !is_throttle;
  assign is_beacon   = is_special && (frame_value[5:0] >= CMD_BEACON_LO) &&
                       (frame_value[5:0] <= CMD_BEACON_HI);
  // Expiry is the edge on which the timer would land on TIMEOUT_CYCLES; a good
  // frame in that same cycle takes priority.
  assign expire      = !good && (timer_q >= TMO_LAST);

  dshot_cmd_repeat #(.CMD_REPEAT(CMD_REPEAT)) u_cmd_repeat (
    .clk         (clk),
    .rst         (rst),
    .good_i      (good),
    .value_i     (frame_value[5:0]),
    .is_special_i(is_special),
    .cmd_fire_o  (cmd_fire),
    .cmd_code_o  (cmd_code)
  );

  always_comb begin
    timer_d = timer_q;
    if (good) begin
      timer_d = '0;
    end else if (timer_q != TMO_MAX) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    speed_d    = speed_q;
    reversed_d = reversed_q;
    beep_d     = 1'b0;
    tone_d     = 3'd0;
    unique case (state_q)
      DISARMED, FAILSAFE: begin
        speed_d = 8'd0;
        if (good) begin
          if (!is_zero) begin
            zero_cnt_d = '0;
          end else if (zero_cnt_q == ZERO_LAST) begin
            state_d    = ARMED;
            zero_cnt_d = '0;
          end else begin
            zero_cnt_d = zero_cnt_q + 1'b1;
          end
        end
      end
      ARMED: begin
        if (good) begin
          speed_d = is_throttle ? frame_value[10:3] : 8'd0;
          if (is_beacon) begin
            beep_d = 1'b1;
            tone_d = frame_value[2:0];
          end
          if (cmd_fire) begin
            if (cmd_code == CMD_DIR_1 || cmd_code == CMD_DIR_NORMAL) begin
              reversed_d = 1'b0;
            end else if (cmd_code == CMD_DIR_2 || cmd_code == CMD_DIR_REVERSED) begin
              reversed_d = 1'b1;
            end
          end
        end else if (expire) begin
          state_d = FAILSAFE;
          speed_d = 8'd0;
        end
      end
      default: begin
        state_d = DISARMED;
        speed_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DISARMED;
      zero_cnt_q <= '0;
      timer_q    <= '0;
      speed_q    <= 8'd0;
      reversed_q <= 1'b0;
      beep_q     <= 1'b0;
      tone_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      timer_q    <= timer_d;
      speed_q    <= speed_d;
      reversed_q <= reversed_d;
      beep_q     <= beep_d;
      tone_q     <= tone_d;
    end
  end

  assign speed_out   = speed_q;
  assign armed       = (state_q == ARMED);
  assign failsafe    = (state_q == FAILSAFE);
  assign reversed    = reversed_q;
  assign beep_strobe = beep_q;
  assign beep_tone   = tone_q;

endmodule

// File: tb/tb_dshot_arming_controller.sv
// Directed bench for dshot_arming_controller with a shortened loss-of-signal timeout.
module tb_dshot_arming_controller;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_strobe = 1'b0;
  logic [10:0] frame_value = '0;
  logic        frame_crc_ok = 1'b0;
  logic [7:0]  speed_out;
  logic        armed, failsafe, reversed, beep_strobe;
  logic [2:0]  beep_tone;

  int total = 0;
  int bad   = 0;

  dshot_arming_controller #(
    .ARM_FRAMES    (10),
    .CMD_REPEAT    (6),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_strobe(frame_strobe),
    .frame_value (frame_value),
    .frame_crc_ok(frame_crc_ok),
    .speed_out   (speed_out),
    .armed       (armed),
    .failsafe    (failsafe),
    .reversed    (reversed),
    .beep_strobe (beep_strobe),
    .beep_tone   (beep_tone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Frame presented for one cycle; returns on the negedge after it was sampled.
  task automatic send(input logic [10:0] v, input logic ok);
    @(negedge clk);
    frame_strobe = 1'b1;
    frame_value  = v;
    frame_crc_ok = ok;
    @(negedge clk);
    frame_strobe = 1'b0;
    frame_crc_ok = 1'b0;
  endtask

  task automatic send_n(input logic [10:0] v, input int n);
    for (int i = 0; i < n; i++) send(v, 1'b1);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_speed", speed_out, 0);
    check("rst_armed", armed, 0);
    check("rst_failsafe", failsafe, 0);
    check("rst_reversed", reversed, 0);
    check("rst_beep", beep_strobe, 0);
    check("rst_tone", beep_tone, 0);

    // Arming
    send_n(11'd0, 9);
    check("arm_after9", armed, 0);
    send(11'd0, 1'b1);
    check("arm_after10", armed, 1);
    check("arm_speed", speed_out, 0);

    // Throttle and CRC-bad frames
    send(11'd1047, 1'b1);
    check("thr_1047", speed_out, 130);
    send(11'd1600, 1'b0);
    check("crcbad_speed", speed_out, 130);
    send(11'd0, 1'b1);
    check("zero_speed", speed_out, 0);
    check("zero_armed", armed, 1);

    // Direction command repeat qualification
    send_n(11'd21, 5);
    send(11'd7, 1'b1);
    check("dir_broken_seq", reversed, 0);
    send_n(11'd21, 5);
    check("dir_after5", reversed, 0);
    send(11'd21, 1'b1);
    check("dir_after6", reversed, 1);
    check("dir_speed", speed_out, 0);
    send(11'd21, 1'b1);
    check("dir_after7", reversed, 1);

    // Beacon
    send(11'd1047, 1'b1);
    send(11'd3, 1'b1);
    check("beep_strobe", beep_strobe, 1);
    check("beep_tone", beep_tone, 3);
    check("beep_speed", speed_out, 0);
    @(negedge clk);
    check("beep_oneshot", beep_strobe, 0);

    // Timeout with a CRC-bad frame in the middle (must not clear the timer)
    send(11'd1600, 1'b1);
    check("to_speed200", speed_out, 200);
    repeat (40) @(negedge clk);
    send(11'd1600, 1'b0);
    repeat (57) @(negedge clk);
    check("to_before", failsafe, 0);
    @(negedge clk);
    check("to_failsafe", failsafe, 1);
    check("to_armed", armed, 0);
    check("to_speed", speed_out, 0);
    send(11'd1600, 1'b1);
    check("fs_thr_speed", speed_out, 0);
    check("fs_thr_state", failsafe, 1);
    send_n(11'd0, 9);
    check("fs_rearm9", armed, 0);
    send(11'd0, 1'b1);
    check("fs_rearm_armed", armed, 1);
    check("fs_rearm_failsafe", failsafe, 0);
    check("fs_rearm_reversed", reversed, 1);

    // Good frame on exactly the expiry cycle
    send(11'd1600, 1'b1);
    repeat (98) @(negedge clk);
    send(11'd1047, 1'b1);
    check("edge_failsafe", failsafe, 0);
    check("edge_armed", armed, 1);
    check("edge_speed", speed_out, 130);
    repeat (99) @(negedge clk);
    check("edge_restart_before", failsafe, 0);
    @(negedge clk);
    check("edge_restart_after", failsafe, 1);

    // Reset clears everything; beacon ignored while disarmed
    pulse_rst();
    check("rst2_failsafe", failsafe, 0);
    check("rst2_reversed", reversed, 0);
    send(11'd3, 1'b1);
    check("disarm_beep", beep_strobe, 0);

    // Reset mid-count
    send_n(11'd0, 7);
    pulse_rst();
    send_n(11'd0, 9);
    check("midrst_after9", armed, 0);
    send(11'd0, 1'b1);
    check("midrst_after10", armed, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dshot_arming_controller.md
Name: dshot_arming_controller

Overview:
Sequences the DShot speed datapath: takes decoded frames from the DShot receiver and decides what reaches the motor output. It enforces the arming sequence, a loss-of-signal failsafe, repeat-qualified special commands (spin direction) and beacon requests. It sits between the DShot frame decoder and the PWM/motor speed output, replacing the bare latch-last-valid-speed logic.

Parameters:
ARM_FRAMES, 10, consecutive CRC-valid zero-value frames needed to arm or re-arm
CMD_REPEAT, 6, consecutive identical CRC-valid frames needed to execute a direction command
TIMEOUT_CYCLES, 2500000, clk cycles without a CRC-valid frame before failsafe (50 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_strobe  in  1  one-cycle pulse: frame decoded, other frame_* inputs valid this cycle
frame_value  in  11  raw DShot value: 0 = stop, 1-47 = special command, 48-2047 = throttle
frame_crc_ok  in  1  CRC check result for this frame
speed_out  out  8  motor speed 0-255
armed  out  1  high in ARMED state
failsafe  out  1  high in FAILSAFE state
reversed  out  1  current spin direction, 1 = reversed
beep_strobe  out  1  one-cycle beacon request
beep_tone  out  3  beacon number 1-5, valid with beep_strobe

Behaviour:
- Reset: state DISARMED; speed_out=0, armed=0, failsafe=0, reversed=0, beep_strobe=0, beep_tone=0; all counters 0.
- Good frame = frame_strobe & frame_crc_ok. Frames with frame_crc_ok=0 are ignored completely: no counter, timer or output change.
- All outputs are registered and update on the clk edge after the good-frame cycle (1-cycle latency).
- States: DISARMED, ARMED, FAILSAFE.
- DISARMED: speed_out forced to 0. A good frame with value 0 increments zero_cnt. Any other good frame clears zero_cnt. When zero_cnt reaches ARM_FRAMES: go to ARMED and clear zero_cnt.
- ARMED:
  - Throttle frame (48-2047): speed_out = frame_value[10:3].
  - Value 0: speed_out = 0; stay ARMED.
  - Special command (1-47): speed_out = 0 and the command is processed.
- FAILSAFE: failsafe=1, armed=0, speed_out=0. Uses the same zero-frame counting as DISARMED. After ARM_FRAMES zero frames: go to ARMED and clear failsafe. reversed is preserved.
- Timeout timer: counts clk cycles and clears on every good frame. It saturates at TIMEOUT_CYCLES. When it reaches TIMEOUT_CYCLES in ARMED, go to FAILSAFE on that edge. In DISARMED and FAILSAFE it has no effect.
- Simultaneous good frame and timer expiry in the same cycle: the frame wins; timer clears and the frame is processed normally.
- Repeat counter: holds last_cmd and rep_cnt.
  - A good special frame equal to last_cmd increments rep_cnt, saturating at CMD_REPEAT.
  - A different special value loads last_cmd and sets rep_cnt=1.
  - A throttle or zero frame clears rep_cnt.
  - Execution fires once, on the frame where rep_cnt becomes CMD_REPEAT. Further identical frames do not re-fire.
- Commands (ARMED only; ignored in DISARMED/FAILSAFE):
  - 1-5 (beacon): beep_strobe=1 for one cycle with beep_tone = value, on every such frame; no repeat needed.
  - 7 or 20: reversed <= 0, after repeat qualification.
  - 8 or 21: reversed <= 1, after repeat qualification.
  - All other values 6, 9-19, 22-47: speed 0, otherwise no effect.
- Reset asserted mid-sequence (during counting or in FAILSAFE): returns everything to reset values on that edge.

Decomposition:
- Shared package dshot_pkg holds:
  - Constants: THROTTLE_MIN=48, CMD_BEACON_LO=1, CMD_BEACON_HI=5, CMD_DIR_1=7, CMD_DIR_2=8, CMD_DIR_NORMAL=20, CMD_DIR_REVERSED=21.
  - The state enum (DISARMED, ARMED, FAILSAFE), shared with the decoder and telemetry.
- One sub-module: dshot_cmd_repeat.
  - Inputs: clk, rst, good-frame strobe, value, is_special.
  - Output: one-cycle cmd_fire with cmd_code.
  - Implements the last_cmd/rep_cnt logic.
- The top level holds the FSM, timeout timer and output registers.

Test Plan:
- Reset, then 9 good zero frames -> armed=0. 10th frame -> armed=1 one cycle later; speed_out=0.
- Armed, good frame value 1047 -> speed_out=130. Same value with frame_crc_ok=0 -> speed_out unchanged; timer not cleared.
- Armed, 5 frames of 21 then 1 frame of 7 -> reversed stays 0. Then 6 frames of 21 -> reversed=1 after the 6th. 7th frame -> no re-fire.
- Armed, single frame value 3 -> beep_strobe one cycle with beep_tone=3; speed_out=0. Same frame while DISARMED -> no beep.
- Armed at speed 200, no frames for TIMEOUT_CYCLES (reduced to 100 in the bench) -> failsafe=1, armed=0, speed_out=0. Throttle frames are ignored. 10 zero frames -> armed=1, failsafe=0, reversed retained.
- A good frame arriving on exactly the expiry cycle -> no failsafe. rst asserted at zero_cnt=7 -> counter cleared; 10 more zero frames are needed to arm.
